i2c_sub_controller: RTL and testbench
=====================================

Name: i2c_sub_controller

Overview:
Protocol sequencer for the I2C subordinate interface. It runs on the system clock and synchronises SCL/SDA. It detects START and STOP, matches the device address, and generates the bit counter and phase strobes that drive the memory address checker and the register memory. It owns the open-drain SDA drive for ACK and read data.

Parameters:
DEV_ADDR, 7'h42, 7-bit subordinate device address matched in the first byte
SYNC_STAGES, 2, flop stages on scl_in/sda_in before edge detection (min 2)

Ports:
clk  input  1  system clock; all state on posedge clk
rst_n  input  1  asynchronous active-low reset
scl_in  input  1  raw SCL pin
sda_in  input  1  raw SDA pin
sda_oe  output  1  1 = pull SDA low; 0 = release
clock_count  output  4  bit index within current byte: 0..7 data, 8 = ACK slot
read_mem_address  output  1  high during memory-address byte and one clk after its bit 7
increment_mem_address  output  1  1-clk pulse: advance memory address
mem_read_bit  input  1  read flag from address checker
mem_write_bit  input  1  write flag from address checker
mem_wr_en  output  1  1-clk pulse, wr_data valid
wr_data  output  8  received data byte, MSB first
mem_rd_en  output  1  1-clk pulse requesting rd_data
rd_data  input  8  memory read data, valid 1 clk after mem_rd_en
busy  output  1  high from START until STOP/abort

Behaviour:
- Reset values: all outputs 0; state IDLE; shift registers 0.
- Sync: scl_s/sda_s after SYNC_STAGES flops. Edges are detected against the previous sample.
- START: sda_s falls while scl_s = 1. STOP: sda_s rises while scl_s = 1. Both are valid in every state and take priority over bit handling.
- Bit rules:
  - SDA is sampled on scl_s rise.
  - sda_oe, clock_count and phase outputs change only on scl_s fall. The exception is START/STOP, which reset them immediately.
  - clock_count increments 0..8 on each scl fall and wraps 8->0.
- States:
  - IDLE: waits for START -> DEV_ADDR, busy = 1, clock_count = 0.
  - DEV_ADDR: shifts 8 bits.
    - At the fall after bit 7: if addr == DEV_ADDR and R/W = 0 -> DEV_ACK with sda_oe = 1.
    - Otherwise -> WAIT_STOP with sda_oe = 0.
  - DEV_ACK: at ACK fall -> MEM_ADDR, sda_oe = 0, read_mem_address = 1.
  - MEM_ADDR: 7 address bits then R/W flag, captured by the checker on scl. read_mem_address drops 1 clk after the scl fall following bit 7, so the checker loads memory_address. Then -> MEM_ACK, sda_oe = 1.
  - MEM_ACK: at ACK fall, sda_oe = 0.
    - If mem_write_bit -> WR_DATA.
    - If mem_read_bit -> RD_DATA: pulse mem_rd_en, load rd_data into the tx shifter next clk, drive bit 7 (sda_oe = ~bit).
  - WR_DATA: at the bit-7 rise, pulse mem_wr_en with wr_data. At the next fall -> WR_ACK, sda_oe = 1.
  - WR_ACK: at ACK fall, sda_oe = 0, increment_mem_address pulse -> WR_DATA.
  - RD_DATA: on each fall drive the next bit; after bit 0 release -> RD_ACK.
  - RD_ACK: master ACK (sda = 0 at rise) -> increment pulse, then at the fall mem_rd_en -> RD_DATA. NACK -> WAIT_STOP.
  - WAIT_STOP: sda_oe = 0; ignores bits until STOP/START.
- STOP in any state: -> IDLE, busy = 0, sda_oe = 0, clock_count = 0.
- Repeated START: -> DEV_ADDR; partial byte discarded, no mem_wr_en.
- Reset mid-transfer: SDA released within the reset assertion; no pulses.
- Address wrap 7'h7F -> 7'h00 is the checker's responsibility. The controller pulses unconditionally.
- increment_mem_address and mem_wr_en are never asserted in the same clk.

Optional Feature:
I2C_GLITCH_FILTER_EN:
- Defined: a 3-sample majority filter follows the synchroniser on both lines. Adds 2 clk latency; rejects pulses shorter than 2 clk.
- Undefined: the synchronised lines are used directly.

Decomposition:
- Package i2c_pkg: state enum i2c_state_t (IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP), ACK_SLOT = 4'd8, default DEV_ADDR constant.
- Sub-module i2c_line_sync: synchroniser, optional filter, and scl_rise/scl_fall/start/stop pulse outputs.

Test Plan:
- Write to 0x42, mem 0x10, data 0xA5, 0x3C, STOP -> ACKs on all 4 bytes; mem_wr_en with 0xA5 then 0x3C; 2 increment pulses; busy 0 after STOP.
- Read from 0x42, mem 0x05, rd_data 0x81 then 0x7E, master ACK then NACK -> SDA carries 0x81, 0x7E; mem_rd_en ×2; WAIT_STOP after NACK.
- Device address 0x43 -> no ACK (sda_oe stays 0), no strobes until STOP.
- Repeated START after 4 data bits -> no mem_wr_en, clock_count = 0, state DEV_ADDR.
- rst_n low during the RD_DATA bit-3 drive -> sda_oe = 0 asynchronously; all outputs 0; next START handled normally.
- With I2C_GLITCH_FILTER_EN: 1-clk SCL low glitch during DEV_ADDR -> clock_count unchanged. Without the macro -> bit miscount, NACK.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C subordinate controller.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_MEM_ADDR,
        ST_MEM_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic [3:0] ACK_SLOT         = 4'd8;
    localparam logic [3:0] LAST_BIT         = 4'd7;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h42;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// Build option I2C_GLITCH_FILTER_EN inserts a 3-sample majority filter
// after the synchroniser (2 clk extra latency, rejects 1-clk pulses).
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;
    logic scl_line, sda_line;

    // shift raw pins into the synchroniser chains
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end

    // chains reset to the idle-high bus level so no edge is seen on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d;
    logic [1:0] sda_hist_q, sda_hist_d;
    logic scl_filt_q, scl_filt_d;
    logic sda_filt_q, sda_filt_d;

    // majority vote over the current and two previous synchronised samples
    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
        scl_filt_d = maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
        sda_filt_d = maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end

    // filter history and registered filter output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_line = scl_filt_q;
    assign sda_line = sda_filt_q;
`else
    assign scl_line = scl_sync_q[SYNC_STAGES-1];
    assign sda_line = sda_sync_q[SYNC_STAGES-1];
`endif

    // previous sample for edge detection
    always_comb begin
        scl_prev_d = scl_line;
        sda_prev_d = sda_line;
    end

    // previous-sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_s     = sda_line;
    assign scl_rise  = scl_line & ~scl_prev_q;
    assign scl_fall  = ~scl_line & scl_prev_q;
    assign start_det = scl_line & scl_prev_q & sda_prev_q & ~sda_line;
    assign stop_det  = scl_line & scl_prev_q & ~sda_prev_q & sda_line;

endmodule

// File: rtl/i2c_sub_controller.sv
// I2C subordinate protocol sequencer: address match, bit counting, phase
// strobes for the address checker / register memory, open-drain SDA drive.
// Optional build macro: I2C_GLITCH_FILTER_EN (majority filter on SCL/SDA).
//
// state        | meaning
// ST_IDLE      | bus free, waiting for START
// ST_DEV_ADDR  | shifting device address + R/W
// ST_DEV_ACK   | driving ACK for matched device address
// ST_MEM_ADDR  | memory address byte, checker loads it
// ST_MEM_ACK   | driving ACK for memory address byte
// ST_WR_DATA   | receiving a write data byte
// ST_WR_ACK    | driving ACK for write data
// ST_RD_DATA   | driving read data bits MSB first
// ST_RD_ACK    | sampling master ACK/NACK
// ST_WAIT_STOP | not addressed / NACKed, idle until STOP or START
module i2c_sub_controller
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [3:0] clock_count,
    output logic       read_mem_address,
    output logic       increment_mem_address,
    input  logic       mem_read_bit,
    input  logic       mem_write_bit,
    output logic       mem_wr_en,
    output logic [7:0] wr_data,
    output logic       mem_rd_en,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rma_q, rma_d;
    logic       inc_q, inc_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       busy_q, busy_d;
    logic       load_q, load_d;
    logic       first_q, first_d;

    // next-state, counters and strobes; START/STOP override bit handling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        wr_data_d = wr_data_q;
        sda_oe_d  = sda_oe_q;
        rma_d     = rma_q;
        busy_d    = busy_q;
        first_d   = first_q;
        inc_d     = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        load_d    = 1'b0;

        // checker has had the full address byte; drop the load strobe
        if (state_q == ST_MEM_ACK) rma_d = 1'b0;

        // rd_data is valid one clk after mem_rd_en: present its MSB
        if (load_q) begin
            tx_d     = rd_data;
            sda_oe_d = ~rd_data[7];
        end

        if (start_det) begin
            state_d  = ST_DEV_ADDR;
            busy_d   = 1'b1;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            rma_d    = 1'b0;
            shift_d  = '0;
            first_d  = 1'b1;   // the SCL fall that completes START is not a bit
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            rma_d    = 1'b0;
            first_d  = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (scl_rise && !first_q) begin
                shift_d = {shift_q[6:0], sda_s};
                if (state_q == ST_WR_DATA && cnt_q == LAST_BIT) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {shift_q[6:0], sda_s};
                end
                if (state_q == ST_RD_ACK) begin
                    if (!sda_s) inc_d   = 1'b1;
                    else        state_d = ST_WAIT_STOP;
                end
            end
            if (scl_fall) begin
                if (first_q) begin
                    first_d = 1'b0;
                end else begin
                    cnt_d = (cnt_q == ACK_SLOT) ? 4'd0 : cnt_q + 4'd1;
                    case (state_q)
                        ST_DEV_ADDR: if (cnt_q == LAST_BIT) begin
                            if (shift_q == {DEV_ADDR, 1'b0}) begin
                                state_d  = ST_DEV_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = ST_WAIT_STOP;
                                sda_oe_d = 1'b0;
                            end
                        end
                        ST_DEV_ACK: if (cnt_q == ACK_SLOT) begin
                            state_d  = ST_MEM_ADDR;
                            sda_oe_d = 1'b0;
                            rma_d    = 1'b1;
                        end
                        ST_MEM_ADDR: if (cnt_q == LAST_BIT) begin
                            state_d  = ST_MEM_ACK;
                            sda_oe_d = 1'b1;
                        end
                        ST_MEM_ACK: if (cnt_q == ACK_SLOT) begin
                            sda_oe_d = 1'b0;
                            if (mem_write_bit) begin
                                state_d = ST_WR_DATA;
                            end else if (mem_read_bit) begin
                                state_d = ST_RD_DATA;
                                rd_en_d = 1'b1;
                                load_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                        ST_WR_DATA: if (cnt_q == LAST_BIT) begin
                            state_d  = ST_WR_ACK;
                            sda_oe_d = 1'b1;
                        end
                        ST_WR_ACK: if (cnt_q == ACK_SLOT) begin
                            state_d  = ST_WR_DATA;
                            sda_oe_d = 1'b0;
                            inc_d    = 1'b1;
                        end
                        ST_RD_DATA: begin
                            if (cnt_q == LAST_BIT) begin
                                state_d  = ST_RD_ACK;
                                sda_oe_d = 1'b0;
                            end else begin
                                sda_oe_d = ~tx_q[6];
                                tx_d     = {tx_q[6:0], 1'b0};
                            end
                        end
                        ST_RD_ACK: begin
                            state_d = ST_RD_DATA;
                            rd_en_d = 1'b1;
                            load_d  = 1'b1;
                        end
                        ST_WAIT_STOP: sda_oe_d = 1'b0;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        end
    end

    // controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            wr_data_q <= '0;
            sda_oe_q  <= 1'b0;
            rma_q     <= 1'b0;
            inc_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_data_q <= wr_data_d;
            sda_oe_q  <= sda_oe_d;
            rma_q     <= rma_d;
            inc_q     <= inc_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            load_q    <= load_d;
            first_q   <= first_d;
        end
    end

    assign sda_oe                = sda_oe_q;
    assign clock_count           = cnt_q;
    assign read_mem_address      = rma_q;
    assign increment_mem_address = inc_q;
    assign mem_wr_en             = wr_en_q;
    assign wr_data               = wr_data_q;
    assign mem_rd_en             = rd_en_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_i2c_sub_controller.sv
// Directed bench for i2c_sub_controller: bus-master tasks, a memory
// responder and write/read scoreboards.
module tb_i2c_sub_controller;
    import i2c_pkg::*;

    localparam int T = 16;   // clk cycles per SCL quarter/half phase
`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [3:0] GL_CNT   = 4'd2;
    localparam logic       GL_ACK   = 1'b1;
    localparam i2c_state_t GL_STATE = ST_MEM_ADDR;
`else
    localparam logic [3:0] GL_CNT   = 4'd3;
    localparam logic       GL_ACK   = 1'b0;
    localparam i2c_state_t GL_STATE = ST_WAIT_STOP;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [3:0] clock_count;
    logic       read_mem_address, increment_mem_address;
    logic       mem_read_bit = 1'b0, mem_write_bit = 1'b0;
    logic       mem_wr_en, mem_rd_en, busy;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;

    assign sda_in = sda_m & ~sda_oe;

    i2c_sub_controller dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .scl_in                (scl_in),
        .sda_in                (sda_in),
        .sda_oe                (sda_oe),
        .clock_count           (clock_count),
        .read_mem_address      (read_mem_address),
        .increment_mem_address (increment_mem_address),
        .mem_read_bit          (mem_read_bit),
        .mem_write_bit         (mem_write_bit),
        .mem_wr_en             (mem_wr_en),
        .wr_data               (wr_data),
        .mem_rd_en             (mem_rd_en),
        .rd_data               (rd_data),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int wr_cnt = 0, inc_cnt = 0, rd_cnt = 0, strobe_cnt = 0;
    logic oe_seen = 1'b0;
    logic [7:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] rd_src_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // memory responder and strobe scoreboard, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (mem_wr_en) begin
            wr_cnt++;
            if (exp_wr_q.size() > 0) chk("wr_data", {24'd0, wr_data}, {24'd0, exp_wr_q.pop_front()});
        end
        if (mem_wr_en | increment_mem_address)
            chk("wr_inc_excl", {31'd0, mem_wr_en & increment_mem_address}, 32'd0);
        if (increment_mem_address) inc_cnt++;
        if (mem_rd_en) begin
            rd_cnt++;
            rd_data = (rd_src_q.size() > 0) ? rd_src_q.pop_front() : 8'h00;
        end
        if (mem_wr_en | increment_mem_address | mem_rd_en | read_mem_address) strobe_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic i2c_start();
        sda_m = 1'b1;  wait_clk(T);
        scl_in = 1'b1; wait_clk(T);
        sda_m = 1'b0;  wait_clk(T);
        scl_in = 1'b0; wait_clk(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;  wait_clk(T);
        scl_in = 1'b1; wait_clk(T);
        sda_m = 1'b1;  wait_clk(T);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b;     wait_clk(T);
        scl_in = 1'b1; wait_clk(T/2);
        if (glitch) begin
            scl_in = 1'b0; wait_clk(1);
            scl_in = 1'b1; wait_clk(T/2);
            chk("glitch_cnt", {28'd0, clock_count}, {28'd0, GL_CNT});
        end
        wait_clk(T/2);
        scl_in = 1'b0; wait_clk(T);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
        sda_m = 1'b1;  wait_clk(T);
        scl_in = 1'b1; wait_clk(T);
        ack = ~sda_in;
        scl_in = 1'b0; wait_clk(T);
    endtask

    task automatic read_byte(input string tag, input logic master_ack);
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1;  wait_clk(T);
            scl_in = 1'b1; wait_clk(T);
            got[i] = sda_in;
            scl_in = 1'b0; wait_clk(T);
        end
        chk(tag, {24'd0, got}, {24'd0, exp_rd_q.pop_front()});
        sda_m = ~master_ack; wait_clk(T);
        scl_in = 1'b1;       wait_clk(T);
        scl_in = 1'b0;       wait_clk(T);
        sda_m = 1'b1;
    endtask

    initial begin
        logic ack;
        int wr0, inc0, rd0, st0;

        // reset state
        wait_clk(3);
        chk("rst_outputs", {sda_oe, clock_count, read_mem_address, increment_mem_address,
                            mem_wr_en, wr_data, mem_rd_en, busy}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);
        chk("rst_state", dut.state_q, ST_IDLE);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // write 0xA5, 0x3C at mem 0x10
        mem_write_bit = 1'b1; mem_read_bit = 1'b0;
        wr0 = wr_cnt; inc0 = inc_cnt;
        i2c_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_state", dut.state_q, ST_DEV_ADDR);
        send_byte(8'h84, -1, ack);
        chk("t1_dev_ack", {31'd0, ack}, 32'd1);
        chk("t1_rma_set", {31'd0, read_mem_address}, 32'd1);
        send_byte(8'h10, -1, ack);
        chk("t1_mem_ack", {31'd0, ack}, 32'd1);
        chk("t1_rma_drop", {31'd0, read_mem_address}, 32'd0);
        exp_wr_q.push_back(8'hA5);
        send_byte(8'hA5, -1, ack);
        chk("t1_d0_ack", {31'd0, ack}, 32'd1);
        exp_wr_q.push_back(8'h3C);
        send_byte(8'h3C, -1, ack);
        chk("t1_d1_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        chk("t1_busy_stop", {31'd0, busy}, 32'd0);
        chk("t1_wr_count", wr_cnt - wr0, 32'd2);
        chk("t1_inc_count", inc_cnt - inc0, 32'd2);
        chk("t1_cnt_stop", {28'd0, clock_count}, 32'd0);

        // read 0x81 (master ACK) then 0x7E (NACK) from mem 0x05
        mem_write_bit = 1'b0; mem_read_bit = 1'b1;
        rd_src_q.push_back(8'h81); exp_rd_q.push_back(8'h81);
        rd_src_q.push_back(8'h7E); exp_rd_q.push_back(8'h7E);
        rd0 = rd_cnt; inc0 = inc_cnt;
        i2c_start();
        send_byte(8'h84, -1, ack);
        chk("t2_dev_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h05, -1, ack);
        chk("t2_mem_ack", {31'd0, ack}, 32'd1);
        read_byte("t2_rd0", 1'b1);
        read_byte("t2_rd1", 1'b0);
        chk("t2_state_nack", dut.state_q, ST_WAIT_STOP);
        chk("t2_rd_count", rd_cnt - rd0, 32'd2);
        chk("t2_inc_count", inc_cnt - inc0, 32'd1);
        i2c_stop();
        chk("t2_busy_stop", {31'd0, busy}, 32'd0);

        // wrong device address 0x43
        mem_write_bit = 1'b1; mem_read_bit = 1'b0;
        oe_seen = 1'b0; st0 = strobe_cnt;
        i2c_start();
        send_byte(8'h86, -1, ack);
        chk("t3_no_ack", {31'd0, ack}, 32'd0);
        chk("t3_state", dut.state_q, ST_WAIT_STOP);
        send_byte(8'h10, -1, ack);
        chk("t3_no_ack2", {31'd0, ack}, 32'd0);
        chk("t3_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("t3_strobes", strobe_cnt - st0, 32'd0);
        i2c_stop();
        chk("t3_busy_stop", {31'd0, busy}, 32'd0);

        // repeated START after 4 data bits
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'h84, -1, ack);
        send_byte(8'h10, -1, ack);
        chk("t4_mem_ack", {31'd0, ack}, 32'd1);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        i2c_start();
        chk("t4_cnt", {28'd0, clock_count}, 32'd0);
        chk("t4_state", dut.state_q, ST_DEV_ADDR);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_no_wr", wr_cnt - wr0, 32'd0);
        i2c_stop();

        // reset while driving read data bit 3
        mem_write_bit = 1'b0; mem_read_bit = 1'b1;
        rd_src_q.push_back(8'h00);
        i2c_start();
        send_byte(8'h84, -1, ack);
        send_byte(8'h05, -1, ack);
        chk("t5_mem_ack", {31'd0, ack}, 32'd1);
        for (int i = 7; i >= 4; i--) begin
            sda_m = 1'b1;  wait_clk(T);
            scl_in = 1'b1; wait_clk(T);
            scl_in = 1'b0; wait_clk(T);
        end
        chk("t5_bit3_drive", {31'd0, sda_oe}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("t5_rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("t5_rst_outputs", {sda_oe, clock_count, read_mem_address, increment_mem_address,
                               mem_wr_en, wr_data, mem_rd_en, busy}, 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        mem_write_bit = 1'b1; mem_read_bit = 1'b0;
        st0 = strobe_cnt;
        i2c_start();
        send_byte(8'h84, -1, ack);
        chk("t5_after_rst_ack", {31'd0, ack}, 32'd1);
        chk("t5_after_rst_state", dut.state_q, ST_MEM_ADDR);
        i2c_stop();
        chk("t5_busy_stop", {31'd0, busy}, 32'd0);

        // 1-clk SCL low glitch during device address bit 2
        i2c_start();
        send_byte(8'h84, 5, ack);
        chk("t6_ack", {31'd0, ack}, {31'd0, GL_ACK});
        chk("t6_state", dut.state_q, GL_STATE);
        i2c_stop();
        chk("t6_busy_stop", {31'd0, busy}, 32'd0);

        wait_clk(4);
        chk("wr_queue_empty", exp_wr_q.size(), 32'd0);
        chk("rd_queue_empty", exp_rd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
